cc_lose_control: RTL
====================

CC_LOSE_CONTROL -- requirements
Module: cc_lose_control

Interface
REQ-001 SHALL have parameter LIVES, default 3, meaning lives loaded at game start (1..3).
REQ-002 SHALL have parameter CONFIRM_TICKS, default 2, meaning consecutive ticks loseIn must be high to count a collision (1..3).
REQ-003 SHALL have parameter HIT_TICKS, default 8, meaning ticks the game is frozen after a counted collision (1..15).
REQ-004 SHALL have parameter BLINK_TICKS, default 4, meaning ticks per blink half-period in HIT and GAMEOVER (1..15).
REQ-005 SHALL have one clock and an asynchronous, active-low reset: CC_LOSE_CONTROL_CLOCK_50  input  1  system clock, rising edge.
REQ-006 SHALL have CC_LOSE_CONTROL_RESET_InLow  input  1  asynchronous active-low reset.
REQ-007 SHALL have CC_LOSE_CONTROL_tick_InHigh  input  1  one-cycle game frame tick.
REQ-008 SHALL have CC_LOSE_CONTROL_start_InHigh  input  1  one-cycle debounced start pulse.
REQ-009 SHALL have CC_LOSE_CONTROL_lose_InHigh  input  1  level from the collision comparator, 1 = overlap.
REQ-010 SHALL have CC_LOSE_CONTROL_run_OutHigh  output  1  enable for road/obstacle/car logic.
REQ-011 SHALL have CC_LOSE_CONTROL_lives_Out  output  2  remaining lives.
REQ-012 SHALL have CC_LOSE_CONTROL_blink_OutHigh  output  1  display blink phase.
REQ-013 SHALL have CC_LOSE_CONTROL_gameover_OutHigh  output  1  level, game lost.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, HIT, GAMEOVER; all outputs registered.
REQ-015 SHALL, in IDLE on start, load lives=LIVES, clear all counters, enter RUN next cycle.
REQ-016 SHALL sample lose_InHigh only on tick cycles in RUN; confirm counter increments on tick with lose=1, clears on tick with lose=0, holds between ticks.
REQ-017 SHALL, when confirm counter reaches CONFIRM_TICKS, decrement lives by 1, clear confirm counter, enter HIT on that same clock edge.
REQ-018 SHALL drive run_OutHigh=1 only in RUN; 0 in IDLE, HIT, GAMEOVER.
REQ-019 SHALL, in HIT, count HIT_TICKS ticks, then enter RUN if lives>0, else GAMEOVER.
REQ-020 SHALL toggle blink_OutHigh every BLINK_TICKS ticks in HIT and GAMEOVER; blink=0 in IDLE and RUN, blink counter cleared on state entry.
REQ-021 SHALL drive gameover_OutHigh=1 only in GAMEOVER.
REQ-022 SHALL, in GAMEOVER on start, reload lives=LIVES and enter RUN directly.
REQ-023 SHALL ignore start in RUN and HIT; ignore lose_InHigh outside RUN.
REQ-024 SHALL give start priority over tick when both occur in the same cycle in IDLE or GAMEOVER; the tick is not counted.
REQ-025 SHALL saturate lives at 0 (no wrap to 3).
REQ-026 SHALL treat lose_InHigh as possibly glitchy between ticks; only tick-cycle values matter.

Reset
REQ-027 SHALL on RESET_InLow=0 asynchronously force IDLE, run=0, lives=0, blink=0, gameover=0, all counters 0.
REQ-028 SHALL, on reset mid-HIT or mid-RUN, discard all progress; first cycle after release is IDLE.

Structure
REQ-029 SHALL place state encodings (2-bit) and counter widths in shared package/include CC_GAME_pkg.
REQ-030 SHALL use one sub-module CC_TICK_COUNTER (tick-enabled 4-bit counter with clear and terminal-count flag) instanced for hit and blink timing.

Verification
REQ-031 SHALL verify: reset, start pulse -> run=1, lives=3 one cycle later.
REQ-032 SHALL verify: lose=1 on 2 consecutive ticks in RUN -> lives=2, run=0, state HIT; 8 ticks later run=1.
REQ-033 SHALL verify: lose=1 on tick, 0 on next tick, 1 on next -> no life lost.
REQ-034 SHALL verify: 3 confirmed collisions -> lives=0, gameover=1, blink toggles every 4 ticks; start -> run=1, lives=3, gameover=0.
REQ-035 SHALL verify: lose pulses only between ticks -> lives unchanged; start in RUN -> no effect.
REQ-036 SHALL verify: reset asserted mid-HIT -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/CC_GAME_pkg.sv
// Shared encodings and widths for the game control blocks.
package CC_GAME_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned CONF_W  = 2;

  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN      = 2'd1;
  localparam logic [STATE_W-1:0] ST_HIT      = 2'd2;
  localparam logic [STATE_W-1:0] ST_GAMEOVER = 2'd3;

  // Lives never wrap below zero.
  function automatic logic [LIVES_W-1:0] lives_dec(input logic [LIVES_W-1:0] l);
    return (l == '0) ? '0 : l - LIVES_W'(1);
  endfunction

endpackage

// File: rtl/CC_TICK_COUNTER.sv
// Tick-enabled wrap-around counter with clear; tc_c flags the enabled cycle that wraps.
module CC_TICK_COUNTER
  import CC_GAME_pkg::*;
#(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  assign tc_c = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cc_lose_control.sv
// Lives/collision control: confirms collisions on frame ticks, freezes the game
// while hit, and reports game over with a blinking display phase.
module cc_lose_control
  import CC_GAME_pkg::*;
#(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned CONFIRM_TICKS = 2,
  parameter int unsigned HIT_TICKS     = 8,
  parameter int unsigned BLINK_TICKS   = 4
) (
  input  logic               CC_LOSE_CONTROL_CLOCK_50,
  input  logic               CC_LOSE_CONTROL_RESET_InLow,
  input  logic               CC_LOSE_CONTROL_tick_InHigh,
  input  logic               CC_LOSE_CONTROL_start_InHigh,
  input  logic               CC_LOSE_CONTROL_lose_InHigh,
  output logic               CC_LOSE_CONTROL_run_OutHigh,
  output logic [LIVES_W-1:0] CC_LOSE_CONTROL_lives_Out,
  output logic               CC_LOSE_CONTROL_blink_OutHigh,
  output logic               CC_LOSE_CONTROL_gameover_OutHigh
);

  localparam logic [CONF_W-1:0]  CONF_LAST  = CONF_W'(CONFIRM_TICKS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  logic clk;
  logic rst_n;
  logic tick;
  logic start;
  logic lose;

  assign clk   = CC_LOSE_CONTROL_CLOCK_50;
  assign rst_n = CC_LOSE_CONTROL_RESET_InLow;
  assign tick  = CC_LOSE_CONTROL_tick_InHigh;
  assign start = CC_LOSE_CONTROL_start_InHigh;
  assign lose  = CC_LOSE_CONTROL_lose_InHigh;

  logic [STATE_W-1:0] state, state_d;
  logic [CONF_W-1:0]  conf_q, conf_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               run_q, run_d;
  logic               blink_q, blink_d;
  logic               go_q, go_d;

  logic hit_clr, hit_en, hit_tc_c;
  logic blink_clr, blink_en, blink_tc_c;
  logic blink_state;

  assign blink_state = (state == ST_HIT) || (state == ST_GAMEOVER);
  assign hit_clr     = (state != ST_HIT);
  assign hit_en      = tick && (state == ST_HIT);
  assign blink_en    = tick && blink_state;
  // Blink timing restarts whenever the state changes or leaves the blinking states.
  assign blink_clr   = !blink_state || (state_d != state);

  CC_TICK_COUNTER #(.LIMIT(HIT_TICKS)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hit_clr),
    .en    (hit_en),
    .tc_c  (hit_tc_c)
  );

  CC_TICK_COUNTER #(.LIMIT(BLINK_TICKS)) u_blink_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (blink_clr),
    .en    (blink_en),
    .tc_c  (blink_tc_c)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      conf_q  <= '0;
      lives_q <= '0;
      run_q   <= 1'b0;
      blink_q <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state   <= state_d;
      conf_q  <= conf_d;
      lives_q <= lives_d;
      run_q   <= run_d;
      blink_q <= blink_d;
      go_q    <= go_d;
    end
  end

  // Next-state and next-output logic; start wins over tick in IDLE/GAMEOVER.
  always_comb begin
    state_d = state;
    conf_d  = '0;
    lives_d = lives_q;
    case (state)
      ST_IDLE, ST_GAMEOVER: begin
        if (start) begin
          state_d = ST_RUN;
          lives_d = LIVES_INIT;
        end
      end
      ST_RUN: begin
        conf_d = conf_q;
        if (tick) begin
          if (!lose) begin
            conf_d = '0;
          end else if (conf_q == CONF_LAST) begin
            conf_d  = '0;
            lives_d = lives_dec(lives_q);
            state_d = ST_HIT;
          end else begin
            conf_d = conf_q + CONF_W'(1);
          end
        end
      end
      ST_HIT: begin
        if (hit_tc_c) begin
          state_d = (lives_q != '0) ? ST_RUN : ST_GAMEOVER;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    run_d = (state_d == ST_RUN);
    go_d  = (state_d == ST_GAMEOVER);
    if (blink_clr) begin
      blink_d = 1'b0;
    end else if (blink_tc_c) begin
      blink_d = !blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  assign CC_LOSE_CONTROL_run_OutHigh      = run_q;
  assign CC_LOSE_CONTROL_lives_Out        = lives_q;
  assign CC_LOSE_CONTROL_blink_OutHigh    = blink_q;
  assign CC_LOSE_CONTROL_gameover_OutHigh = go_q;

endmodule
